// File: rtl/mips_pkg.sv
// Shared definitions for the fetch-stage sequencer: state encodings and
// the default halt-instruction encoding.
package mips_pkg;

   typedef logic [2:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE = 3'd0;
   localparam fetch_state_t ST_LOAD = 3'd1;
   localparam fetch_state_t ST_RUN  = 3'd2;
   localparam fetch_state_t ST_STEP = 3'd3;
   localparam fetch_state_t ST_HALT = 3'd4;

   localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between fetch_ctrl and its neighbours (loader, debug unit,
// hazard/branch logic, PC and program memory). slave = fetch_ctrl side.
interface fetch_ctrl_if #(
   parameter int ADDR_W = 11
);
   logic              load_valid;
   logic              load_ready;
   logic [31:0]       load_data;
   logic              load_last;
   logic              run_cmd;
   logic              step_cmd;
   logic              halt_cmd;
   logic              stall;
   logic              branch_taken;
   logic [31:0]       branch_target;
   logic [31:0]       instr;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic              pc_enable;
   logic              pc_use_npc;
   logic [31:0]       pc_jump_address;
   logic              flush;
   logic [2:0]        state;
   logic [31:0]       fetch_count;

   modport master (
      output load_valid, load_data, load_last, run_cmd, step_cmd, halt_cmd,
             stall, branch_taken, branch_target, instr,
      input  load_ready, imem_we, imem_waddr, imem_wdata, pc_enable,
             pc_use_npc, pc_jump_address, flush, state, fetch_count
   );

   modport slave (
      input  load_valid, load_data, load_last, run_cmd, step_cmd, halt_cmd,
             stall, branch_taken, branch_target, instr,
      output load_ready, imem_we, imem_waddr, imem_wdata, pc_enable,
             pc_use_npc, pc_jump_address, flush, state, fetch_count
   );
endinterface

// File: rtl/fetch_ctrl_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module fetch_ctrl_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clock,
   input  logic             i_reset_n,
   input  logic             i_clear,
   input  logic             i_enable,
   output logic [WIDTH-1:0] o_count
);
   logic [WIDTH-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: program load, run/step/halt FSM, PC gating, fetch count.
// Optional macro FETCH_CTRL_HALT_WORD_EN enables the in-RUN halt-instruction detector.
module fetch_ctrl
   import mips_pkg::*;
#(
   parameter int          ADDR_W    = 11,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   fetch_ctrl_if.slave bus
);
   fetch_state_t      r_state;
   fetch_state_t      w_state_next;
   logic [ADDR_W-1:0] r_waddr;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_waddr;
   logic [31:0]       r_imem_wdata;
   logic              w_exec;
   logic              w_pc_enable;
   logic              w_redirect;
   logic              w_accept;
   logic              w_enter_load;
   logic              w_halt_hit;
   logic [31:0]       w_fetch_count;

`ifdef FETCH_CTRL_HALT_WORD_EN
   assign w_halt_hit = (bus.instr == HALT_WORD);
`else
   logic w_unused;
   assign w_unused   = ^{bus.instr, HALT_WORD};
   assign w_halt_hit = 1'b0;
`endif

   assign w_exec       = (r_state == ST_RUN) || (r_state == ST_STEP);
   // A taken branch must reach the PC even while the hazard unit stalls.
   assign w_pc_enable  = w_exec && (!bus.stall || bus.branch_taken);
   assign w_redirect   = w_exec && bus.branch_taken;
   assign w_accept     = (r_state == ST_LOAD) && bus.load_valid;
   assign w_enter_load = ((r_state == ST_IDLE) || (r_state == ST_HALT)) && bus.load_valid;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE, ST_HALT: begin
            if (bus.load_valid)     w_state_next = ST_LOAD;
            else if (bus.run_cmd)   w_state_next = ST_RUN;
            else if (bus.step_cmd)  w_state_next = ST_STEP;
         end
         ST_LOAD: begin
            if (w_accept && bus.load_last) w_state_next = ST_IDLE;
         end
         ST_RUN: begin
            if (bus.halt_cmd || w_halt_hit) w_state_next = ST_HALT;
         end
         ST_STEP: begin
            // A stalled step keeps waiting for its single enabled fetch.
            if (w_pc_enable) w_state_next = ST_HALT;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state      <= ST_IDLE;
         r_waddr      <= '0;
         r_imem_we    <= 1'b0;
         r_imem_waddr <= '0;
         r_imem_wdata <= '0;
      end else begin
         r_state   <= w_state_next;
         r_imem_we <= w_accept;
         if (w_enter_load) begin
            r_waddr <= '0;
         end else if (w_accept) begin
            r_waddr      <= r_waddr + 1'b1;
            r_imem_waddr <= r_waddr;
            r_imem_wdata <= bus.load_data;
         end
      end
   end

   fetch_ctrl_counter #(
      .WIDTH (32)
   ) u_fetch_counter (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_clear   (w_enter_load),
      .i_enable  (w_pc_enable),
      .o_count   (w_fetch_count)
   );

   assign bus.load_ready      = (r_state == ST_LOAD);
   assign bus.imem_we         = r_imem_we;
   assign bus.imem_waddr      = r_imem_waddr;
   assign bus.imem_wdata      = r_imem_wdata;
   assign bus.pc_enable       = w_pc_enable;
   assign bus.pc_use_npc      = w_redirect;
   assign bus.flush           = w_redirect;
   assign bus.pc_jump_address = w_redirect ? bus.branch_target : 32'h0;
   assign bus.state           = r_state;
   assign bus.fetch_count     = w_fetch_count;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus pushes per-cycle expectations from a
// rule-level reference model, a negedge monitor pops and compares.
module tb_fetch_ctrl;
   localparam int          ADDR_W = 11;
   localparam logic [31:0] HW     = 32'hFFFF_FFFF;
`ifdef FETCH_CTRL_HALT_WORD_EN
   localparam bit HW_EN = 1'b1;
`else
   localparam bit HW_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   fetch_ctrl #(.ADDR_W(ADDR_W), .HALT_WORD(HW)) dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus.slave)
   );

   typedef struct {
      bit          chk;
      logic [2:0]  st;
      bit          lr;
      bit          pe;
      bit          npc;
      logic [31:0] ja;
      bit          we;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [31:0] fc;
   } exp_t;

   exp_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;

   // Reference model: mode names as plain integers, memory pointer as a
   // modular word index, count as a saturating number.
   int          m_mode  = 0;
   int unsigned m_ptr   = 0;
   bit          m_we    = 0;
   int unsigned m_wa    = 0;
   logic [31:0] m_wd    = 0;
   logic [31:0] m_fc    = 0;
   bit          m_known = 0;
   bit          last_acc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
      end
   endtask

   // Called at posedge+1 with this cycle's inputs already driven.
   task automatic tick(input bit rv);
      exp_t e;
      bit exec, pe, acc;
      rst_n = rv;
      exec = (m_mode == 2) || (m_mode == 3);
      pe   = exec && (!bus.stall || bus.branch_taken);
      acc  = (m_mode == 1) && bus.load_valid;
      e.chk = m_known;
      e.st  = 3'(m_mode);
      e.lr  = (m_mode == 1);
      e.pe  = pe;
      e.npc = exec && bus.branch_taken;
      e.ja  = (exec && bus.branch_taken) ? bus.branch_target : 32'h0;
      e.we  = m_we;
      e.wa  = m_wa;
      e.wd  = m_wd;
      e.fc  = m_fc;
      q.push_back(e);
      last_acc = acc;
      if (!rv) begin
         m_mode = 0; m_ptr = 0; m_we = 0; m_wa = 0; m_wd = 0; m_fc = 0; m_known = 1;
      end else if (m_known) begin
         m_we = acc;
         if (acc) begin
            m_wa  = m_ptr;
            m_wd  = bus.load_data;
            m_ptr = (m_ptr + 1) % (1 << ADDR_W);
         end
         if (pe && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
         case (m_mode)
            0, 4: begin
               if (bus.load_valid) begin m_mode = 1; m_ptr = 0; m_fc = 0; end
               else if (bus.run_cmd) m_mode = 2;
               else if (bus.step_cmd) m_mode = 3;
            end
            1: if (acc && bus.load_last) m_mode = 0;
            2: if (bus.halt_cmd || (HW_EN && bus.instr == HW)) m_mode = 4;
            3: if (pe) m_mode = 4;
            default: m_mode = 0;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.load_valid = 0; bus.load_last = 0; bus.load_data = 0;
      bus.run_cmd = 0; bus.step_cmd = 0; bus.halt_cmd = 0;
      bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0; bus.instr = 0;
   endtask

   task automatic load_words(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         bus.load_valid = 1;
         bus.load_data  = rnd ? $urandom : 32'(8'h11 * (i + 1));
         bus.load_last  = (i == n - 1);
         last_acc = 0;
         while (!last_acc) begin
            tick(1);
            guard++;
            if (guard > 4) begin
               check("load_accept_timeout", 32'(guard), 32'd1);
               break;
            end
         end
      end
      quiet();
      tick(1);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if (e.chk) begin
            if (bus.imem_we)
               $display("write addr=%0d data=%h", bus.imem_waddr, bus.imem_wdata);
            check("state", 32'(bus.state), 32'(e.st));
            check("load_ready", 32'(bus.load_ready), 32'(e.lr));
            check("pc_enable", 32'(bus.pc_enable), 32'(e.pe));
            check("pc_use_npc", 32'(bus.pc_use_npc), 32'(e.npc));
            check("flush", 32'(bus.flush), 32'(e.npc));
            if (e.npc) check("pc_jump_address", bus.pc_jump_address, e.ja);
            check("imem_we", 32'(bus.imem_we), 32'(e.we));
            check("imem_waddr", 32'(bus.imem_waddr), e.wa);
            check("imem_wdata", bus.imem_wdata, e.wd);
            check("fetch_count", bus.fetch_count, e.fc);
         end
      end
   end

   initial begin
      quiet();
      @(posedge clk);
      #1;
      tick(0);
      tick(0);

      // three-word program
      load_words(3, 0);
      check("load3_done_state", 32'(bus.state), 32'd0);

      // run, ten counted fetches including the halt cycle
      bus.run_cmd = 1; tick(1); bus.run_cmd = 0;
      repeat (9) tick(1);
      bus.halt_cmd = 1; tick(1); bus.halt_cmd = 0;
      check("run_halt_state", 32'(bus.state), 32'd4);
      check("run_halt_count", bus.fetch_count, 32'd10);
      tick(1);

      // branch overrides stall
      bus.run_cmd = 1; tick(1); bus.run_cmd = 0;
      bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 32'h40; tick(1);
      bus.branch_taken = 0; tick(1);
      bus.stall = 0; bus.halt_cmd = 1; tick(1); bus.halt_cmd = 0;

      // stalled single step
      bus.step_cmd = 1; tick(1); bus.step_cmd = 0;
      bus.stall = 1; tick(1); tick(1);
      bus.stall = 0; tick(1);
      check("step_end_state", 32'(bus.state), 32'd4);
      tick(1);

      // halt instruction while running
      bus.run_cmd = 1; tick(1); bus.run_cmd = 0;
      bus.instr = HW; tick(1);
      bus.instr = 0;
      check("halt_word_state", 32'(bus.state), HW_EN ? 32'd4 : 32'd2);
      tick(1);
      bus.halt_cmd = 1; tick(1); bus.halt_cmd = 0; tick(1);

      // address wrap over a full memory plus one
      load_words((1 << ADDR_W) + 1, 1);

      // reset in the middle of a transfer
      bus.load_valid = 1; bus.load_data = 32'hA5A5_0001;
      repeat (4) tick(1);
      tick(0);
      quiet();
      repeat (3) tick(1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bus.load_valid    = ($urandom_range(0, 7) == 0);
         bus.load_last     = ($urandom_range(0, 7) == 0);
         bus.load_data     = $urandom;
         bus.run_cmd       = ($urandom_range(0, 9) == 0);
         bus.step_cmd      = ($urandom_range(0, 9) == 0);
         bus.halt_cmd      = ($urandom_range(0, 19) == 0);
         bus.stall         = ($urandom_range(0, 2) == 0);
         bus.branch_taken  = ($urandom_range(0, 3) == 0);
         bus.branch_target = $urandom;
         bus.instr         = ($urandom_range(0, 24) == 0) ? HW : $urandom;
         tick(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
      end

      quiet();
      repeat (3) tick(1);
      begin
         int guard = 0;
         while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (q.size() > 0) check("scoreboard_drain", 32'(q.size()), 32'd0);
      end
      #2;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the instruction-fetch stage: owns the program-memory write port during program load and gates the PC during execution. Runs a five-state machine (IDLE/LOAD/RUN/STEP/HALT) driven by the loader stream and the debug unit's run/step/halt commands. Folds branch redirects and hazard stalls into PC enable/select, and counts executed fetch cycles. Sits between the loader/debug unit, the hazard/branch logic, and the PC + program memory.

## Interface
- ADDR_W, 11, program-memory word-address width
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that ends execution
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low
- load_valid  in  1  loader presents a word
- load_ready  out  1  block accepts the word
- load_data  in  32  word to write
- load_last  in  1  final word of the program
- run_cmd / step_cmd / halt_cmd  in  1 each  single-cycle debug pulses
- stall  in  1  hazard unit freezes fetch
- branch_taken  in  1  redirect request
- branch_target  in  32  redirect address
- instr  in  32  instruction currently fetched
- imem_we  out  1  program-memory write strobe
- imem_waddr  out  ADDR_W  write address
- imem_wdata  out  32  write data
- pc_enable  out  1  PC advances this cycle
- pc_use_npc  out  1  PC loads pc_jump_address
- pc_jump_address  out  32  redirect address to PC
- flush  out  1  kill instruction in IF/ID
- state  out  3  current state encoding
- fetch_count  out  32  cycles with pc_enable=1

## Operation
- Encoding: IDLE=0, LOAD=1, RUN=2, STEP=3, HALT=4.
- IDLE/HALT exits, priority: load_valid -> LOAD; else run_cmd -> RUN; else step_cmd -> STEP.
- LOAD: load_ready=1. Each load_valid&load_ready registers imem_we=1, imem_waddr, imem_wdata=load_data; then waddr increments. At 2**ADDR_W-1 it wraps to 0 with no error. An accepted word with load_last=1 -> IDLE.
- Entering LOAD clears waddr and fetch_count.
- RUN: halt_cmd -> HALT. HALT_WORD detect (see Configuration) -> HALT. Both in one cycle -> HALT, once.
- STEP: exactly one cycle, then HALT. If stall is high and no branch, STEP holds until one enabled fetch occurs, then HALT.
- pc_enable = (RUN|STEP) & (~stall | branch_taken). A branch overrides stall.
- pc_use_npc = flush = (RUN|STEP) & branch_taken. pc_jump_address = branch_target. In other states all three are 0 and branch_taken is ignored.
- run/step/halt commands are ignored in LOAD. halt_cmd is ignored in IDLE/HALT.
- fetch_count increments when pc_enable=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset values (reset low at a clock edge): state=IDLE, load_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, fetch_count=0. pc_enable, pc_use_npc and flush are 0 because they decode from IDLE.
- Reset mid-LOAD abandons the transfer: no further writes, waddr=0.
- State transitions take effect one cycle after the triggering input.
- Memory write outputs lag the accepted handshake by 1 cycle.
- load_ready is a Moore output of LOAD: high in every LOAD cycle, low elsewhere.
- PC controls are combinational from state and same-cycle inputs (0 latency).
- HALT_WORD detect compares instr in the same cycle. That instruction's fetch cycle still counts, and pc_enable is low from the next cycle.

## Configuration
- FETCH_CTRL_HALT_WORD_EN defined: in RUN, instr==HALT_WORD moves the block to HALT.
- Undefined: the comparator is absent and only halt_cmd leaves RUN. The HALT_WORD parameter remains but is unused.

## Structure
- Shared package mips_pkg holds:
  - the state enum/localparams (IDLE..HALT)
  - the HALT_WORD default constant
- Sub-module fetch_ctrl_counter: 32-bit saturating counter with clear and enable, reused for fetch_count.
- The FSM, load path and PC-control decode stay in fetch_ctrl.

## Test plan
- Load 3 words (0x11, 0x22, 0x33, last on the third) -> imem_we pulses at waddr 0, 1, 2 with matching data; state returns to 0.
- ADDR_W=2, load 5 words -> fifth word written at waddr 0 (wrap).
- run_cmd, 10 free cycles, then halt_cmd -> state=4, fetch_count=10 (counted through the cycle halt_cmd is sampled), pc_enable=0 afterwards.
- RUN with stall=1 and branch_taken=1, branch_target=0x40 -> pc_enable=1, pc_use_npc=1, flush=1, pc_jump_address=0x40.
- step_cmd from HALT with stall high for 2 cycles -> stays in STEP 2 cycles, 1 enabled fetch, then state=4.
- With FETCH_CTRL_HALT_WORD_EN, instr=0xFFFF_FFFF in RUN -> state=4 next cycle. Without the macro -> remains RUN.
